uart_rx_pkt_parser: RTL and testbench

Packet framing stage directly downstream of `uart_rx`. It consumes the receiver's byte strobes and break flag, and parses framed packets of the form `SOF, LEN, payload[LEN], CSUM`. Payload bytes go into a speculative commit/rollback FIFO. Only packets whose checksum verifies become visible on a valid/ready byte stream, with `m_last` marking each packet's final byte.

---
 rtl/uart_pkt_pkg.sv | 21 ++
 rtl/uart_pkt_fifo.sv | 57 +++++
 rtl/uart_rx_pkt_parser.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_pkt_parser.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// rtl/uart_pkt_pkg.sv - shared types and constants for the UART packet parser
package uart_pkt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_PAYLOAD,
      ST_CSUM,
      ST_DROP
   } pkt_state_e;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_CSUM    = 3'd1;
   localparam logic [2:0] ERR_LEN     = 3'd2;
   localparam logic [2:0] ERR_OVF     = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT = 3'd4;
   localparam logic [2:0] ERR_BREAK   = 3'd5;

   localparam logic [7:0] SOF_DEFAULT = 8'h7E;

endpackage

// File: rtl/uart_pkt_fifo.sv
// rtl/uart_pkt_fifo.sv - 9-bit {last,data} FIFO with speculative write, commit and rollback
module uart_pkt_fifo #(
   parameter int DEPTH = 32
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   wr_en,
   input  logic [8:0]             wr_din,
   input  logic                   commit,
   input  logic                   rollback,
   input  logic                   rd_en,
   output logic [$clog2(DEPTH):0] free,
   output logic                   rd_valid,
   output logic [8:0]             rd_dout
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [8:0]    mem_q [DEPTH];
   logic [PW-1:0] rd_q;
   logic [PW-1:0] wr_commit_q;
   logic [PW-1:0] wr_spec_q;

   // Free space counts speculative bytes so a packet in flight reserves its room.
   assign free     = PW'(DEPTH) - (wr_spec_q - rd_q);
   assign rd_valid = (wr_commit_q != rd_q);
   assign rd_dout  = rd_valid ? mem_q[rd_q[AW-1:0]] : 9'h000;

   // Storage array; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_en && !rollback) begin
         mem_q[wr_spec_q[AW-1:0]] <= wr_din;
      end
   end

   // Pointer update: rollback discards speculative data, commit publishes it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_q        <= '0;
         wr_commit_q <= '0;
         wr_spec_q   <= '0;
      end else begin
         if (rollback) begin
            wr_spec_q <= wr_commit_q;
         end else if (wr_en) begin
            wr_spec_q <= wr_spec_q + PW'(1);
         end
         if (commit) begin
            wr_commit_q <= wr_spec_q;
         end
         if (rd_en && rd_valid) begin
            rd_q <= rd_q + PW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_rx_pkt_parser.sv
// rtl/uart_rx_pkt_parser.sv - SOF/LEN/payload/CSUM framer feeding a commit/rollback FIFO
module uart_rx_pkt_parser
   import uart_pkt_pkg::*;
#(
   parameter logic [7:0] SOF            = SOF_DEFAULT,
   parameter int         MAX_LEN        = 16,
   parameter int         FIFO_DEPTH     = 32,
   parameter int         TIMEOUT_CYCLES = 150000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       rx_break,
   output logic       m_valid,
   output logic [7:0] m_data,
   output logic       m_last,
   input  logic       m_ready,
   output logic       pkt_ok,
   output logic       pkt_err,
   output logic [2:0] err_code
);
   localparam int            PW        = $clog2(FIFO_DEPTH) + 1;
   localparam int            CW        = $clog2(MAX_LEN + 2);
   localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

   pkt_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    sum_q, sum_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          pkt_ok_q, pkt_ok_d;
   logic          pkt_err_q, pkt_err_d;
   logic [2:0]    err_code_q, err_code_d;

   logic          wr_en, commit, rollback;
   logic [8:0]    wr_din;
   logic [PW-1:0] free;
   logic          rd_valid;
   logic [8:0]    rd_dout;

   logic          byte_v;
   logic          busy;
   logic [7:0]    sum_add;

   // A break masks byte strobes in every state, including IDLE.
   assign byte_v  = rx_valid & ~rx_break;
   assign busy    = (state_q != ST_IDLE);
   assign sum_add = sum_q + rx_data;

   assign m_valid  = rd_valid;
   assign m_data   = rd_dout[7:0];
   assign m_last   = rd_dout[8];
   assign pkt_ok   = pkt_ok_q;
   assign pkt_err  = pkt_err_q;
   assign err_code = err_code_q;

   uart_pkt_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .resetn   (resetn),
      .wr_en    (wr_en),
      .wr_din   (wr_din),
      .commit   (commit),
      .rollback (rollback),
      .rd_en    (m_ready),
      .free     (free),
      .rd_valid (rd_valid),
      .rd_dout  (rd_dout)
   );

   // State, counters and registered status pulses.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         sum_q      <= '0;
         tmo_q      <= '0;
         pkt_ok_q   <= 1'b0;
         pkt_err_q  <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sum_q      <= sum_d;
         tmo_q      <= tmo_d;
         pkt_ok_q   <= pkt_ok_d;
         pkt_err_q  <= pkt_err_d;
         err_code_q <= err_code_d;
      end
   end

   // Next-state logic: break beats timeout, timeout beats byte handling.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sum_d      = sum_q;
      tmo_d      = (busy && !byte_v) ? tmo_q + TW'(1) : '0;
      pkt_ok_d   = 1'b0;
      pkt_err_d  = 1'b0;
      err_code_d = err_code_q;
      wr_en      = 1'b0;
      wr_din     = {cnt_q == CW'(1), rx_data};
      commit     = 1'b0;
      rollback   = 1'b0;

      if (busy && rx_break) begin
         rollback   = 1'b1;
         pkt_err_d  = 1'b1;
         err_code_d = ERR_BREAK;
         state_d    = ST_IDLE;
         tmo_d      = '0;
      end else if (busy && tmo_q == TMO_LAST) begin
         rollback   = 1'b1;
         pkt_err_d  = 1'b1;
         err_code_d = ERR_TIMEOUT;
         state_d    = ST_IDLE;
         tmo_d      = '0;
      end else if (byte_v) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_data == SOF) begin
                  state_d = ST_LEN;
               end
            end
            ST_LEN: begin
               if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
                  pkt_err_d  = 1'b1;
                  err_code_d = ERR_LEN;
                  state_d    = ST_IDLE;
               end else if (16'(free) < 16'(rx_data)) begin
                  // Swallow the payload and the checksum byte.
                  pkt_err_d  = 1'b1;
                  err_code_d = ERR_OVF;
                  cnt_d      = CW'(rx_data) + CW'(1);
                  state_d    = ST_DROP;
               end else begin
                  cnt_d   = CW'(rx_data);
                  sum_d   = rx_data;
                  state_d = ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               wr_en = 1'b1;
               sum_d = sum_add;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = ST_CSUM;
               end
            end
            ST_CSUM: begin
               if (sum_add == 8'h00) begin
                  commit   = 1'b1;
                  pkt_ok_d = 1'b1;
               end else begin
                  rollback   = 1'b1;
                  pkt_err_d  = 1'b1;
                  err_code_d = ERR_CSUM;
               end
               state_d = ST_IDLE;
            end
            ST_DROP: begin
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_pkt_parser.sv
// tb/tb_uart_rx_pkt_parser.sv - self-checking bench for uart_rx_pkt_parser
module tb_uart_rx_pkt_parser;
   localparam int MAX_LEN = 16;
   localparam int DEPTH   = 32;
   localparam int TMO     = 300;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_break = 1'b0;
   logic       m_ready = 1'b0;
   logic       m_valid, m_last, pkt_ok, pkt_err;
   logic [7:0] m_data;
   logic [2:0] err_code;

   int         checks = 0;
   int         failures = 0;
   int         ok_cnt = 0;
   int         err_cnt = 0;
   logic [2:0] last_code = 3'd0;
   int         rdy_mode = 0;
   int         b_ok, b_err, k;
   logic [8:0] mon_e;
   logic [7:0] bt;
   logic [8:0] exp_q [$];

   typedef struct {
      int          n;
      logic [63:0] b;
      int          ok;
      int          err;
      logic [2:0]  code;
   } vec_t;
   vec_t vt [7];

   always #5 clk = ~clk;

   uart_rx_pkt_parser #(
      .SOF(8'h7E), .MAX_LEN(MAX_LEN), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_break(rx_break), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
      .m_ready(m_ready), .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_valid = 1'b1;
      rx_data  = b;
      tick(1);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tick(gap);
   endtask

   // Packet-level reference: decide the fate of a packet from free space and its checksum.
   task automatic rand_pkt(input logic [7:0] len, input logic [7:0] delta);
      logic [7:0] pl [$];
      logic [7:0] s, cs;
      int         fr, p_ok, p_err, e_ok, e_err;
      logic [2:0] e_code;
      p_ok = ok_cnt; p_err = err_cnt; e_ok = 0; e_err = 0; e_code = 3'd0; s = len;
      for (int i = 0; i < int'(len); i++) begin
         pl.push_back(8'($urandom));
         s = s + pl[i];
      end
      send_byte(8'h7E, $urandom_range(0, 2));
      fr = DEPTH - exp_q.size();
      send_byte(len, $urandom_range(0, 2));
      if (len == 8'd0 || int'(len) > MAX_LEN) begin
         e_err = 1; e_code = 3'd2;
      end else begin
         if (fr < int'(len)) begin
            e_err = 1; e_code = 3'd3;
         end
         for (int i = 0; i < int'(len); i++) send_byte(pl[i], $urandom_range(0, 2));
         if (e_err == 0) begin
            if (delta == 8'd0) begin
               e_ok = 1;
               for (int i = 0; i < int'(len); i++) exp_q.push_back({i == int'(len) - 1, pl[i]});
            end else begin
               e_err = 1; e_code = 3'd1;
            end
         end
         cs = 8'h00 - s;
         cs = cs + delta;
         send_byte(cs, $urandom_range(0, 2));
      end
      tick(2);
      check("pkt_ok_count", ok_cnt - p_ok, e_ok);
      check("pkt_err_count", err_cnt - p_err, e_err);
      if (e_err != 0) check("pkt_err_code", last_code, e_code);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      rdy_mode = 1;
      while (exp_q.size() != 0 && n < 200) begin
         tick(1);
         n++;
      end
      tick(2);
      check({name, "_left"}, exp_q.size(), 0);
      check({name, "_m_valid"}, m_valid, 0);
   endtask

   // Consumer side: count status pulses and score every popped byte.
   always @(negedge clk) begin
      if (resetn) begin
         if (pkt_ok) ok_cnt++;
         if (pkt_err) begin
            err_cnt++;
            last_code = err_code;
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_byte: actual=%0h required=none", {m_last, m_data});
            end else begin
               mon_e = exp_q.pop_front();
               check("m_byte", {m_last, m_data}, mon_e);
            end
         end else if (!m_valid) begin
            check("idle_zero", {m_last, m_data}, 0);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{6, 64'h7E03_1122_3397_0000, 1, 0, 3'd0};
      vt[1] = '{6, 64'h7E03_1122_3396_0000, 0, 1, 3'd1};
      vt[2] = '{2, 64'h7E00_0000_0000_0000, 0, 1, 3'd2};
      vt[3] = '{2, 64'h7E11_0000_0000_0000, 0, 1, 3'd2};
      vt[4] = '{2, 64'h55AA_0000_0000_0000, 0, 0, 3'd0};
      vt[5] = '{2, 64'h7E7E_0000_0000_0000, 0, 1, 3'd2};
      vt[6] = '{4, 64'h7E01_FF00_0000_0000, 1, 0, 3'd0};

      tick(3);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_last", m_last, 0);
      check("rst_pkt_ok", pkt_ok, 0);
      check("rst_pkt_err", pkt_err, 0);
      check("rst_err_code", err_code, 0);
      resetn = 1'b1;
      tick(2);

      rdy_mode = 1;
      for (int v = 0; v < 7; v++) begin
         b_ok = ok_cnt; b_err = err_cnt;
         for (int i = 0; i < vt[v].n; i++) begin
            bt = vt[v].b[63 - 8*i -: 8];
            if (vt[v].ok != 0 && i == vt[v].n - 1) begin
               for (int j = 2; j < vt[v].n - 1; j++)
                  exp_q.push_back({j == vt[v].n - 2, vt[v].b[63 - 8*j -: 8]});
            end
            send_byte(bt, 1);
         end
         tick(2);
         check("vec_ok", ok_cnt - b_ok, vt[v].ok);
         check("vec_err", err_cnt - b_err, vt[v].err);
         if (vt[v].err != 0) check("vec_code", last_code, vt[v].code);
      end
      drain("vec");

      // Overflow: two full-size packets fill the FIFO, the next LEN cannot fit.
      rdy_mode = 0;
      tick(2);
      rand_pkt(8'd16, 8'd0);
      rand_pkt(8'd16, 8'd0);
      b_ok = ok_cnt; b_err = err_cnt;
      send_byte(8'h7E, 1); send_byte(8'h01, 1); send_byte(8'h5A, 1); send_byte(8'hA5, 1);
      tick(2);
      check("ovf_err", err_cnt - b_err, 1);
      check("ovf_code", last_code, 3);
      check("ovf_ok", ok_cnt - b_ok, 0);
      check("ovf_pending", m_valid, 1);
      b_err = err_cnt;
      send_byte(8'h7E, 1); send_byte(8'h03, 1); send_byte(8'h7E, 1);
      send_byte(8'h01, 1); send_byte(8'h5A, 1); send_byte(8'hA5, 1);
      tick(2);
      check("drop_swallow", err_cnt - b_err, 1);
      drain("ovf");
      rand_pkt(8'd5, 8'd0);
      drain("post_ovf");

      // Timeout mid-payload rolls back the speculative byte.
      b_err = err_cnt;
      send_byte(8'h7E, 0); send_byte(8'h02, 0); send_byte(8'hAA, 0);
      k = 0;
      while (err_cnt == b_err && k < TMO + 50) begin
         tick(1);
         k++;
      end
      check("tmo_err", err_cnt - b_err, 1);
      check("tmo_code", last_code, 4);
      check("tmo_latency", (k >= TMO - 5 && k <= TMO + 5), 1);
      check("tmo_m_valid", m_valid, 0);
      rand_pkt(8'd2, 8'd0);
      drain("tmo");

      // Break mid-payload keeps earlier committed data; break in IDLE masks bytes.
      rdy_mode = 0;
      tick(2);
      rand_pkt(8'd3, 8'd0);
      b_err = err_cnt;
      send_byte(8'h7E, 0); send_byte(8'h04, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
      rx_break = 1'b1;
      tick(2);
      rx_break = 1'b0;
      tick(2);
      check("brk_err", err_cnt - b_err, 1);
      check("brk_code", last_code, 5);
      check("brk_pending", m_valid, 1);
      b_ok = ok_cnt; b_err = err_cnt;
      rx_break = 1'b1;
      send_byte(8'h7E, 1);
      rx_break = 1'b0;
      send_byte(8'h03, 1); send_byte(8'h11, 1); send_byte(8'h22, 1);
      send_byte(8'h33, 1); send_byte(8'h97, 1);
      tick(2);
      check("brk_idle_ok", ok_cnt - b_ok, 0);
      check("brk_idle_err", err_cnt - b_err, 0);
      drain("brk");
      rand_pkt(8'd4, 8'd0);
      drain("post_brk");

      // Reset mid-packet discards committed and speculative data.
      rdy_mode = 0;
      tick(2);
      rand_pkt(8'd3, 8'd0);
      send_byte(8'h7E, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
      resetn = 1'b0;
      exp_q.delete();
      tick(1);
      check("mrst_m_valid", m_valid, 0);
      check("mrst_m_data", m_data, 0);
      check("mrst_m_last", m_last, 0);
      check("mrst_pkt_ok", pkt_ok, 0);
      check("mrst_pkt_err", pkt_err, 0);
      check("mrst_err_code", err_code, 0);
      tick(2);
      resetn = 1'b1;
      tick(2);
      check("mrst_after_valid", m_valid, 0);
      rdy_mode = 1;
      rand_pkt(8'd3, 8'd0);
      drain("mrst");

      // Random traffic with a randomly stalling consumer.
      rdy_mode = 2;
      for (int p = 0; p < 40; p++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind <= 5) begin
            rand_pkt(8'($urandom_range(1, MAX_LEN)), 8'd0);
         end else if (kind <= 7) begin
            rand_pkt(8'($urandom_range(1, MAX_LEN)), 8'($urandom_range(1, 255)));
         end else if (kind == 8) begin
            rand_pkt(($urandom_range(0, 1) != 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)), 8'd0);
         end else begin
            b_ok = ok_cnt; b_err = err_cnt;
            bt = 8'($urandom);
            if (bt == 8'h7E) bt = 8'h00;
            send_byte(bt, 2);
            check("noise_ok", ok_cnt - b_ok, 0);
            check("noise_err", err_cnt - b_err, 0);
         end
      end
      drain("rand");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
